dvp_camera_emulator: RTL and testbench



---
 rtl/dvp_camera_emulator.sv | 136 +++++++++++++
 tb/tb_dvp_camera_emulator.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dvp_camera_emulator.sv
// OV7670-style DVP source: vsync/href framing with RGB565 test patterns, one byte per clock.
// Outputs are registered from next-state values, so each output lines up with the state register.
module dvp_camera_emulator #(
   parameter int unsigned p_width        = 640,
   parameter int unsigned p_height       = 480,
   parameter int unsigned p_hblank       = 144,
   parameter int unsigned p_vsync_lines  = 3,
   parameter int unsigned p_vback_lines  = 17,
   parameter int unsigned p_vfront_lines = 10
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_enable,
   input  logic [1:0]  i_pattern,
   input  logic [15:0] i_color,
   output logic        o_vsync,
   output logic        o_href,
   output logic [7:0]  o_data,
   output logic        o_frame_done,
   output logic        o_busy,
   output logic [7:0]  o_frame_count
);

   localparam int unsigned L    = 2 * p_width + p_hblank;
   localparam int unsigned CW   = (L > 1) ? $clog2(L) : 1;
   localparam int unsigned LM01 = (p_vsync_lines > p_vback_lines) ? p_vsync_lines : p_vback_lines;
   localparam int unsigned LM23 = (p_height > p_vfront_lines) ? p_height : p_vfront_lines;
   localparam int unsigned LMAX = (LM01 > LM23) ? LM01 : LM23;
   localparam int unsigned LW   = (LMAX > 1) ? $clog2(LMAX) : 1;

   typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [LW-1:0] line_q, line_d;
   logic [LW-1:0] last_line;
   logic [1:0]    pat_q;
   logic [15:0]   color_q;
   logic          last_col, frame_end, start;
   logic [15:0]   x, y, pix;
   logic          vsync_q, vsync_d, href_q, href_d, done_q, busy_q, busy_d;
   logic [7:0]    data_q, data_d, count_q;

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      line_d    = line_q;
      frame_end = 1'b0;
      start     = 1'b0;
      last_col  = (col_q == CW'(L - 1));
      case (state_q)
         S_VSYNC:  last_line = LW'(p_vsync_lines - 1);
         S_VBACK:  last_line = LW'(p_vback_lines - 1);
         S_ACTIVE: last_line = LW'(p_height - 1);
         default:  last_line = LW'(p_vfront_lines - 1);
      endcase

      if (state_q == S_IDLE) begin
         if (i_enable) begin
            state_d = S_VSYNC;
            start   = 1'b1;
         end
      end else begin
         col_d = last_col ? '0 : col_q + CW'(1);
         if (last_col) begin
            if (line_q == last_line) begin
               line_d = '0;
               case (state_q)
                  S_VSYNC:  state_d = S_VBACK;
                  S_VBACK:  state_d = S_ACTIVE;
                  S_ACTIVE: state_d = S_VFRONT;
                  default: begin
                     frame_end = 1'b1;
                     start     = i_enable;
                     state_d   = i_enable ? S_VSYNC : S_IDLE;
                  end
               endcase
            end else begin
               line_d = line_q + LW'(1);
            end
         end
      end

      // Pixel for the position the state register is about to hold
      x = 16'(col_d >> 1);
      y = 16'(line_d);
      case (pat_q)
         2'd0:    pix = color_q;
         2'd1:    pix = x;
         2'd2:    pix = y;
         default: pix = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
      endcase
      href_d  = (state_d == S_ACTIVE) && (col_d < CW'(2 * p_width));
      data_d  = href_d ? (col_d[0] ? pix[7:0] : pix[15:8]) : '0;
      vsync_d = (state_d == S_VSYNC);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         col_q   <= '0;
         line_q  <= '0;
         pat_q   <= '0;
         color_q <= '0;
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
         data_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         line_q  <= line_d;
         if (start) begin
            pat_q   <= i_pattern;
            color_q <= i_color;
         end
         vsync_q <= vsync_d;
         href_q  <= href_d;
         data_q  <= data_d;
         done_q  <= frame_end;
         busy_q  <= busy_d;
         if (frame_end) count_q <= count_q + 8'd1;
      end
   end

   assign o_vsync       = vsync_q;
   assign o_href        = href_q;
   assign o_data        = data_q;
   assign o_frame_done  = done_q;
   assign o_busy        = busy_q;
   assign o_frame_count = count_q;

endmodule

// File: tb/tb_dvp_camera_emulator.sv
// Bench for dvp_camera_emulator: two instances (narrow and checkerboard-wide) checked every cycle
// against a frame-time model that derives outputs from the clock index within the frame.
module tb_dvp_camera_emulator;

   localparam int H = 3, HB = 2, VS = 1, VB = 1, VF = 1;
   localparam int W0 = 4, W1 = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [2];
   logic        en  [2];
   logic [1:0]  pat [2];
   logic [15:0] colr[2];

   logic       vs0, hr0, done0, busy0, vs1, hr1, done1, busy1;
   logic [7:0] d0, cnt0, d1, cnt1;

   dvp_camera_emulator #(.p_width(W0), .p_height(H), .p_hblank(HB), .p_vsync_lines(VS),
                         .p_vback_lines(VB), .p_vfront_lines(VF)) dut (
      .i_clk(clk), .i_rst(rst[0]), .i_enable(en[0]), .i_pattern(pat[0]), .i_color(colr[0]),
      .o_vsync(vs0), .o_href(hr0), .o_data(d0), .o_frame_done(done0), .o_busy(busy0),
      .o_frame_count(cnt0));

   dvp_camera_emulator #(.p_width(W1), .p_height(H), .p_hblank(HB), .p_vsync_lines(VS),
                         .p_vback_lines(VB), .p_vfront_lines(VF)) dut_cb (
      .i_clk(clk), .i_rst(rst[1]), .i_enable(en[1]), .i_pattern(pat[1]), .i_color(colr[1]),
      .o_vsync(vs1), .o_href(hr1), .o_data(d1), .o_frame_done(done1), .o_busy(busy1),
      .o_frame_count(cnt1));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model state: whether a frame is running, clock index within it, latched settings
   bit          m_run [2];
   int          m_t   [2];
   logic [1:0]  m_pat [2];
   logic [15:0] m_col [2];
   logic [7:0]  m_cnt [2];
   bit          m_done[2];
   int          hcnt, vcnt;

   function automatic int width_of(input int i);
      return (i == 0) ? W0 : W1;
   endfunction

   task automatic model_update(input int i);
      int frame;
      frame = (VS + VB + H + VF) * (2 * width_of(i) + HB);
      m_done[i] = 0;
      if (rst[i]) begin
         m_run[i] = 0;
         m_t[i]   = 0;
         m_cnt[i] = 0;
      end else if (!m_run[i]) begin
         if (en[i]) begin
            m_run[i] = 1; m_t[i] = 0; m_pat[i] = pat[i]; m_col[i] = colr[i];
         end
      end else begin
         m_t[i]++;
         if (m_t[i] == frame) begin
            m_done[i] = 1;
            m_cnt[i]  = m_cnt[i] + 8'd1;
            if (en[i]) begin
               m_t[i] = 0; m_pat[i] = pat[i]; m_col[i] = colr[i];
            end else begin
               m_run[i] = 0; m_t[i] = 0;
            end
         end
      end
   endtask

   task automatic model_out(input int i, output logic vs, output logic hr, output logic [7:0] d);
      int L, line, col, x, y;
      logic [15:0] px;
      L    = 2 * width_of(i) + HB;
      line = m_t[i] / L;
      col  = m_t[i] % L;
      x    = col / 2;
      y    = line - (VS + VB);
      vs   = m_run[i] && (line < VS);
      hr   = m_run[i] && (y >= 0) && (y < H) && (col < 2 * width_of(i));
      case (m_pat[i])
         2'd0:    px = m_col[i];
         2'd1:    px = 16'(x);
         2'd2:    px = 16'(y);
         default: px = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      endcase
      d = hr ? ((col % 2 == 1) ? px[7:0] : px[15:8]) : 8'h00;
   endtask

   task automatic compare(input int i);
      logic evs, ehr;
      logic [7:0] ed;
      logic [19:0] obs;
      string p;
      obs = (i == 0) ? {vs0, hr0, d0, done0, busy0, cnt0} : {vs1, hr1, d1, done1, busy1, cnt1};
      model_out(i, evs, ehr, ed);
      p = (i == 0) ? "u0" : "u1";
      check({p, ".vsync"}, 32'(obs[19]), 32'(evs));
      check({p, ".href"},  32'(obs[18]), 32'(ehr));
      check({p, ".data"},  32'(obs[17:10]), 32'(ed));
      check({p, ".done"},  32'(obs[9]), 32'(m_done[i]));
      check({p, ".busy"},  32'(obs[8]), 32'(m_run[i]));
      check({p, ".count"}, 32'(obs[7:0]), 32'(m_cnt[i]));
   endtask

   task automatic step();
      for (int i = 0; i < 2; i++) model_update(i);
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) compare(i);
      if (hr0) hcnt++;
      if (vs0) vcnt++;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; en[i] = 1'b0; pat[i] = 2'd0; colr[i] = 16'h0000;
         m_run[i] = 0; m_t[i] = 0; m_pat[i] = 0; m_col[i] = 0; m_cnt[i] = 0; m_done[i] = 0;
      end
      repeat (3) step();
      rst[0] = 1'b0; rst[1] = 1'b0;
      step();

      // single enable pulse, horizontal ramp
      hcnt = 0; vcnt = 0;
      pat[0] = 2'd1; en[0] = 1'b1;
      step();
      en[0] = 1'b0;
      repeat (65) step();
      check("t1.vsync_clocks", 32'(vcnt), 32'd10);
      check("t1.href_clocks", 32'(hcnt), 32'd24);
      check("t1.count", 32'(cnt0), 32'd1);
      check("t1.busy", 32'(busy0), 32'd0);

      // back-to-back solid frames
      pat[0] = 2'd0; colr[0] = 16'hF81F; en[0] = 1'b1;
      repeat (180) step();
      en[0] = 1'b0;
      repeat (5) step();
      check("t2.count", 32'(cnt0), 32'd4);

      // pattern change mid-frame only takes effect on the next frame
      pat[0] = 2'd2; en[0] = 1'b1;
      step();
      repeat (25) step();
      pat[0] = 2'd1;
      repeat (40) step();
      en[0] = 1'b0;
      repeat (60) step();

      // enable dropped during ACTIVE: frame completes, then idle
      en[0] = 1'b1;
      step();
      repeat (25) step();
      en[0] = 1'b0;
      vcnt = 0;
      repeat (50) step();
      check("t4.busy", 32'(busy0), 32'd0);
      check("t4.no_new_vsync", 32'(vcnt), 32'd0);

      // reset during active line 1
      pat[0] = 2'd3; en[0] = 1'b1;
      step();
      en[0] = 1'b0;
      repeat (32) step();
      rst[0] = 1'b1;
      step();
      check("t5.outputs", 32'({vs0, hr0, d0, done0, busy0, cnt0}), 32'd0);
      rst[0] = 1'b0;
      repeat (3) step();

      // checkerboard on the wide instance
      pat[1] = 2'd3; en[1] = 1'b1;
      step();
      en[1] = 1'b0;
      repeat (210) step();
      check("t6.count", 32'(cnt1), 32'd1);

      // randomized traffic on both instances
      repeat (1500) begin
         for (int i = 0; i < 2; i++) begin
            en[i]   = ($urandom_range(0, 2) == 0);
            pat[i]  = 2'($urandom_range(0, 3));
            colr[i] = 16'($urandom);
            rst[i]  = ($urandom_range(0, 299) == 0);
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
